rtype_encoder: RTL and testbench
================================

# rtype_encoder

Monitor-side R-type instruction encoder: the inverse of the controller's ALU decode path. Accepts an ALU operation code in the controller's 3-bit alucontrol encoding plus register fields, rebuilds the MIPS R-type word (opcode 000000, funct field), and writes it into instruction memory at an auto-incrementing word address. The monitor uses it to load test programs into the tinymips core.

## Interface
- ADDR_WIDTH, 6, instruction-memory word-address width; depth 2**ADDR_WIDTH words

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse: load write pointer from start_addr, clear count/err/full
- start_addr  in  ADDR_WIDTH  first word address of a load
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready at clock edge
- in_alucontrol  in  3  operation: 010 ADD, 110 SUB, 000 AND, 001 OR, 111 SLT
- in_rs, in_rt, in_rd  in  5 each  register fields
- imem_we  out  1  instruction-memory write enable, one cycle per word
- imem_addr  out  ADDR_WIDTH  write word address
- imem_wd  out  32  write data
- busy  out  1  high in WRITE state
- full  out  1  sticky: last address written
- err  out  1  sticky: illegal alucontrol received
- count  out  ADDR_WIDTH+1  words written since reset/start

## Operation
- States: IDLE, WRITE, ERR.
- in_ready = (state==IDLE) && !full && !start; combinational.
- IDLE + accept, legal code: register word and ptr into imem_wd/imem_addr, go WRITE.
- IDLE + accept, illegal code (011, 100, 101): no write, err<=1, go ERR.
- WRITE: imem_we=1 for exactly this cycle; at end ptr<=ptr+1, count<=count+1; if ptr was all-ones, full<=1 and ptr holds (no wrap-around); go IDLE.
- ERR: in_ready=0, imem_we=0; leaves only on start or reset.
- Word format: {6'b000000, rs, rt, rd, 5'b00000, funct}; funct: 010->100000, 110->100010, 000->100100, 001->100101, 111->101010.
- start (any state, highest priority): next state IDLE, ptr<=start_addr, count<=0, err<=0, full<=0. A WRITE in progress completes its write in that cycle (imem_we already driven); its count increment is discarded.
- full blocks further accepts until start; in_valid held high while full is ignored.
- Reset: state IDLE, ptr=0, count=0, err=0, full=0, imem_we=0, imem_addr=0, imem_wd=0; busy=0, in_ready=1.

## Timing
- Accept at edge N -> imem_we high during cycle N+1 with imem_addr/imem_wd stable; count updates at end of N+1.
- Throughput: one word per 2 cycles; in_ready low during WRITE.
- imem_addr/imem_wd registered; hold last values when imem_we=0.
- Illegal code accepted at edge N -> err high from cycle N+1; no imem_we.
- start asserted at edge N -> pointer/flags take new values in cycle N+1; in_ready low during cycle of start.
- Memory is assumed to capture on the edge ending the imem_we cycle.

## Test plan
- Reset, start with start_addr=0, send ADD rs=1 rt=2 rd=3 -> one imem_we pulse, addr 0, wd 0x00221820, count=1, 2 cycles from accept.
- Back-to-back in_valid held: SUB rd=4 rs=5 rt=6, SLT rd=8 rs=9 rt=10, OR rd=1 rs=0 rt=0 -> addrs 0,1,2, wd 0x00A62022, 0x012A402A, 0x00000825, in_ready low every other cycle, count=3.
- start_addr=62 (ADDR_WIDTH=6), send 3 legal ops -> writes at 62, 63, then full=1, third held (in_ready=0, no write), count=2.
- Send alucontrol=011 -> err=1, no imem_we, in_ready stays 0; then start -> err=0, next ADD writes normally.
- Assert start in WRITE cycle with start_addr=10 -> current write completes at old addr, count=0, next accept writes addr 10.
- Pull reset_n low mid-WRITE -> all outputs return to reset values immediately, no further imem_we.

Source files
------------

// File: rtl/rtype_encoder.sv
// R-type instruction encoder for the monitor: turns an ALU control code plus register
// fields back into a MIPS R-type word and writes it to instruction memory at a running pointer.
module rtype_encoder #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_alucontrol,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wd,
    output logic                  busy,
    output logic                  full,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wd_q, wd_d;
    logic                  accept;
    logic                  code_legal;

    function automatic logic is_legal(input logic [2:0] code);
        case (code)
            3'b010, 3'b110, 3'b000, 3'b001, 3'b111: is_legal = 1'b1;
            default:                                is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [5:0] funct_of(input logic [2:0] code);
        case (code)
            3'b010:  funct_of = 6'b100000;
            3'b110:  funct_of = 6'b100010;
            3'b000:  funct_of = 6'b100100;
            3'b001:  funct_of = 6'b100101;
            3'b111:  funct_of = 6'b101010;
            default: funct_of = 6'b000000;
        endcase
    endfunction

    function automatic logic [31:0] encode_word(input logic [2:0] code,
                                                input logic [4:0] rs,
                                                input logic [4:0] rt,
                                                input logic [4:0] rd);
        encode_word = {6'b000000, rs, rt, rd, 5'b00000, funct_of(code)};
    endfunction

    assign code_legal = is_legal(in_alucontrol);
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // start overrides every state so the monitor can always recover a load
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d = code_legal ? S_WRITE : S_ERR;
                    end
                end
                S_WRITE: state_d = S_IDLE;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (state_q == S_IDLE) && !full_q && !start;
        imem_we  = (state_q == S_WRITE);
        busy     = (state_q == S_WRITE);
    end

    // A write that coincides with start still reaches memory; only its count bump is lost
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        full_d  = full_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        if (start) begin
            ptr_d   = start_addr;
            count_d = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (code_legal) begin
                            addr_d = ptr_q;
                            wd_d   = encode_word(in_alucontrol, in_rs, in_rt, in_rd);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    count_d = count_q + 1'b1;
                    if (&ptr_q) begin
                        full_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
        end
    end

    assign imem_addr = addr_q;
    assign imem_wd   = wd_q;
    assign full      = full_q;
    assign err       = err_q;
    assign count     = count_q;

endmodule

// File: tb/tb_rtype_encoder.sv
// Bench for rtype_encoder: vector table, directed corner sequences and a randomized
// run against a transaction-level model of the load pointer, count and sticky flags.
module tb_rtype_encoder;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_alucontrol;
    logic [4:0]    in_rs, in_rt, in_rd;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wd;
    logic          busy, full, err;
    logic [AW:0]   count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    rtype_encoder #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .start_addr   (start_addr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_alucontrol(in_alucontrol),
        .in_rs        (in_rs),
        .in_rt        (in_rt),
        .in_rd        (in_rd),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wd      (imem_wd),
        .busy         (busy),
        .full         (full),
        .err          (err),
        .count        (count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [2:0]  a;
        logic [4:0]  s, t, d;
        bit          legal;
        logic [31:0] wd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference encoding straight from the opcode/funct table
    function automatic logic [31:0] ref_word(input logic [2:0] a, input logic [4:0] s,
                                             input logic [4:0] t, input logic [4:0] d);
        int f;
        case (a)
            3'b010:  f = 32;
            3'b110:  f = 34;
            3'b000:  f = 36;
            3'b001:  f = 37;
            3'b111:  f = 42;
            default: f = 0;
        endcase
        return (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | 32'(f);
    endfunction

    function automatic bit ref_legal(input logic [2:0] a);
        return (a == 3'b010) || (a == 3'b110) || (a == 3'b000) || (a == 3'b001) || (a == 3'b111);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int a);
        start      = 1'b1;
        start_addr = AW'(a);
        #1;
        chk("ready_low_during_start", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Present a request and wait (bounded) for it to be accepted; returns at +1 after the accept edge
    task automatic do_req(input logic [2:0] a, input logic [4:0] s, input logic [4:0] t,
                          input logic [4:0] d, output bit ok, output int acc_cyc);
        in_valid      = 1'b1;
        in_alucontrol = a;
        in_rs         = s;
        in_rt         = t;
        in_rd         = d;
        ok            = 1'b0;
        acc_cyc       = -1;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                @(posedge clk);
                acc_cyc = cyc;
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Hold a request for n cycles, counting cycles with in_ready or imem_we high
    task automatic hold_req(input logic [2:0] a, input int n, output int rdy_seen, output int we_seen);
        in_valid      = 1'b1;
        in_alucontrol = a;
        rdy_seen      = 0;
        we_seen       = 0;
        for (int k = 0; k < n; k++) begin
            #1;
            if (in_ready) rdy_seen++;
            if (imem_we) we_seen++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    vec_t vecs[8];
    bit   ok;
    int   acc, prev_acc, rdy_n, we_n;
    int   m_ptr, m_cnt;
    bit   m_full, m_err;
    logic [2:0] codes[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{3'b010, 5'd1,  5'd2,  5'd3,  1'b1, 32'h00221820};
        vecs[1] = '{3'b110, 5'd5,  5'd6,  5'd4,  1'b1, 32'h00A62022};
        vecs[2] = '{3'b111, 5'd9,  5'd10, 5'd8,  1'b1, 32'h012A402A};
        vecs[3] = '{3'b001, 5'd0,  5'd0,  5'd1,  1'b1, 32'h00000825};
        vecs[4] = '{3'b000, 5'd31, 5'd31, 5'd31, 1'b1, 32'h03FFF824};
        vecs[5] = '{3'b011, 5'd1,  5'd2,  5'd3,  1'b0, 32'h0};
        vecs[6] = '{3'b100, 5'd7,  5'd7,  5'd7,  1'b0, 32'h0};
        vecs[7] = '{3'b101, 5'd0,  5'd0,  5'd0,  1'b0, 32'h0};
        codes = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b011, 3'b100, 3'b101};

        reset_n = 1'b0; start = 1'b0; start_addr = '0; in_valid = 1'b0;
        in_alucontrol = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        step(); step();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_busy",     {31'b0, busy},     32'd0);
        chk("rst_we",       {31'b0, imem_we},  32'd0);
        chk("rst_addr",     32'(imem_addr),    32'd0);
        chk("rst_wd",       imem_wd,           32'd0);
        chk("rst_count",    32'(count),        32'd0);
        chk("rst_err_full", {30'b0, err, full}, 32'd0);
        reset_n = 1'b1;
        step();

        // First ADD: write two cycles after accept, count then 1
        pulse_start(0);
        do_req(3'b010, 5'd1, 5'd2, 5'd3, ok, acc);
        chk("add_accept", {31'b0, ok}, 32'd1);
        chk("add_we",     {31'b0, imem_we}, 32'd1);
        chk("add_busy",   {31'b0, busy}, 32'd1);
        chk("add_addr",   32'(imem_addr), 32'd0);
        chk("add_wd",     imem_wd, 32'h00221820);
        chk("add_ready",  {31'b0, in_ready}, 32'd0);
        step();
        chk("add_we_off", {31'b0, imem_we}, 32'd0);
        chk("add_count",  32'(count), 32'd1);
        chk("add_hold_wd", imem_wd, 32'h00221820);

        // Back-to-back with in_valid held: one accept every 2 cycles
        pulse_start(0);
        prev_acc = -1;
        for (int i = 1; i <= 3; i++) begin
            do_req(vecs[i].a, vecs[i].s, vecs[i].t, vecs[i].d, ok, acc);
            chk("b2b_we",   {31'b0, imem_we}, 32'd1);
            chk("b2b_addr", 32'(imem_addr), 32'(i - 1));
            chk("b2b_wd",   imem_wd, vecs[i].wd);
            chk("b2b_ready_low", {31'b0, in_ready}, 32'd0);
            if (prev_acc >= 0) chk("b2b_spacing", 32'(acc - prev_acc), 32'd2);
            prev_acc = acc;
        end
        step();
        chk("b2b_count", 32'(count), 32'd3);

        // Vector table: each entry at its own start address
        for (int i = 0; i < 8; i++) begin
            pulse_start(i * 3);
            do_req(vecs[i].a, vecs[i].s, vecs[i].t, vecs[i].d, ok, acc);
            chk("vec_accept", {31'b0, ok}, 32'd1);
            chk("vec_we",     {31'b0, imem_we}, {31'b0, vecs[i].legal});
            if (vecs[i].legal) begin
                chk("vec_addr", 32'(imem_addr), 32'(i * 3));
                chk("vec_wd",   imem_wd, vecs[i].wd);
                step();
                chk("vec_count", 32'(count), 32'd1);
            end else begin
                chk("vec_err", {31'b0, err}, 32'd1);
                step();
                chk("vec_err_ready", {31'b0, in_ready}, 32'd0);
                chk("vec_err_count", 32'(count), 32'd0);
            end
        end

        // Near the top of memory: 62, 63, then full blocks the third
        pulse_start(62);
        for (int i = 0; i < 2; i++) begin
            do_req(3'b010, 5'd1, 5'd1, 5'd1, ok, acc);
            chk("top_we",   {31'b0, imem_we}, 32'd1);
            chk("top_addr", 32'(imem_addr), 32'(62 + i));
        end
        step();
        chk("top_full", {31'b0, full}, 32'd1);
        hold_req(3'b110, 5, rdy_n, we_n);
        chk("top_full_ready", 32'(rdy_n), 32'd0);
        chk("top_full_we",    32'(we_n),  32'd0);
        chk("top_count",      32'(count), 32'd2);
        chk("top_addr_hold",  32'(imem_addr), 32'd63);

        // Illegal code: sticky err until start
        pulse_start(20);
        do_req(3'b011, 5'd1, 5'd2, 5'd3, ok, acc);
        chk("ill_err", {31'b0, err}, 32'd1);
        chk("ill_we",  {31'b0, imem_we}, 32'd0);
        hold_req(3'b010, 4, rdy_n, we_n);
        chk("ill_ready", 32'(rdy_n), 32'd0);
        chk("ill_no_we", 32'(we_n), 32'd0);
        pulse_start(20);
        chk("ill_err_clr", {31'b0, err}, 32'd0);
        do_req(3'b010, 5'd1, 5'd2, 5'd3, ok, acc);
        chk("ill_rec_we",   {31'b0, imem_we}, 32'd1);
        chk("ill_rec_addr", 32'(imem_addr), 32'd20);
        chk("ill_rec_wd",   imem_wd, 32'h00221820);
        step();

        // start during the WRITE cycle: write lands at old addr, count discarded
        pulse_start(40);
        do_req(3'b001, 5'd3, 5'd4, 5'd5, ok, acc);
        chk("sw_we",   {31'b0, imem_we}, 32'd1);
        chk("sw_addr", 32'(imem_addr), 32'd40);
        pulse_start(10);
        chk("sw_count", 32'(count), 32'd0);
        chk("sw_we_off", {31'b0, imem_we}, 32'd0);
        do_req(3'b010, 5'd1, 5'd2, 5'd3, ok, acc);
        chk("sw_next_addr", 32'(imem_addr), 32'd10);
        step();
        chk("sw_next_count", 32'(count), 32'd1);

        // Reset asserted mid-WRITE
        do_req(3'b110, 5'd7, 5'd8, 5'd9, ok, acc);
        chk("rmw_we", {31'b0, imem_we}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rmw_we0",    {31'b0, imem_we}, 32'd0);
        chk("rmw_busy",   {31'b0, busy}, 32'd0);
        chk("rmw_addr",   32'(imem_addr), 32'd0);
        chk("rmw_wd",     imem_wd, 32'd0);
        chk("rmw_count",  32'(count), 32'd0);
        chk("rmw_ready",  {31'b0, in_ready}, 32'd1);
        step();
        reset_n = 1'b1;
        step();
        chk("rmw_after_we",    {31'b0, imem_we}, 32'd0);
        chk("rmw_after_count", 32'(count), 32'd0);

        // Randomized run against the load model
        m_ptr = 0; m_cnt = 0; m_full = 0; m_err = 0;
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                int sa;
                sa = ($urandom_range(0, 1) == 1) ? $urandom_range(58, 63) : $urandom_range(0, 63);
                pulse_start(sa);
                m_ptr = sa; m_cnt = 0; m_full = 0; m_err = 0;
                chk("rnd_start_count", 32'(count), 32'd0);
                chk("rnd_start_flags", {30'b0, err, full}, 32'd0);
            end else begin
                logic [2:0] a;
                logic [4:0] s, t, d;
                a = ($urandom_range(0, 11) == 0) ? codes[$urandom_range(5, 7)] : codes[$urandom_range(0, 4)];
                s = 5'($urandom); t = 5'($urandom); d = 5'($urandom);
                if (m_full || m_err) begin
                    hold_req(a, 2, rdy_n, we_n);
                    chk("rnd_blocked_ready", 32'(rdy_n), 32'd0);
                    chk("rnd_blocked_we",    32'(we_n),  32'd0);
                end else begin
                    do_req(a, s, t, d, ok, acc);
                    chk("rnd_accept", {31'b0, ok}, 32'd1);
                    if (ref_legal(a)) begin
                        chk("rnd_we",   {31'b0, imem_we}, 32'd1);
                        chk("rnd_addr", 32'(imem_addr), 32'(m_ptr));
                        chk("rnd_wd",   imem_wd, ref_word(a, s, t, d));
                        m_cnt++;
                        if (m_ptr == (1 << AW) - 1) m_full = 1; else m_ptr++;
                        step();
                    end else begin
                        chk("rnd_ill_we", {31'b0, imem_we}, 32'd0);
                        m_err = 1;
                    end
                end
            end
            chk("rnd_count", 32'(count), 32'(m_cnt));
            chk("rnd_flags", {30'b0, err, full}, {30'b0, m_err, m_full});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
